// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port packet BRAM (1-cycle read latency)
// between NREQ requesters. Round-robin arbitration, optional lock for
// atomic bursts, and a burst cap that forces release when others wait.
// Requester map: 0 = rx payload loader, 1 = checksum engine, 2 = tx streamer.
//
// state | meaning
// ARB   | round-robin among requesters, scanning after the last grant
// OWN   | a locked requester owns the port until it lets go or hits the cap
module mem_arbiter #(
  parameter int NREQ      = 3,
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_lock,
  input  logic [NREQ-1:0]   i_we,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_rvalid,
  output logic [DW-1:0]     o_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [AW-1:0]     o_mem_addr,
  output logic [DW-1:0]     o_mem_wdata,
  input  logic [DW-1:0]     i_mem_rdata,
  output logic              o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = 8;
  // Grants left in the current burst window; 0 means the cap is reached.
  localparam logic [BW-1:0] BURST_RELOAD = BW'(MAX_BURST - 1);

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   left_q, left_d;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] owner_mask;
  logic [NREQ-1:0] rvalid_q;
  logic [AW-1:0]   addr_q, mem_addr;
  logic [DW-1:0]   wdata_q, mem_wdata;
  logic            mem_we;
  logic            others;
  logic            keep;
  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;

  assign owner_mask = NREQ'(1) << owner_q;
  assign others     = |(i_req & ~owner_mask);

  // Arbitration FSM state, pointer, owner and burst counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ARB;
      ptr_q   <= IW'(NREQ - 1);
      owner_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      left_q  <= left_d;
    end
  end

  // Grant selection and next state. While in OWN the pointer already equals
  // the owner, so a release re-arbitrates with the owner at lowest priority.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    left_d  = left_q;
    gnt     = '0;
    keep    = 1'b0;
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    if (state_q == OWN) begin
      keep = i_req[owner_q] && i_lock[owner_q] && !((left_q == '0) && others);
    end
    if (keep) begin
      gnt    = owner_mask;
      left_d = (left_q == '0) ? BURST_RELOAD : left_q - BW'(1);
    end else begin
      state_d = ARB;
      for (int i = NREQ; i >= 1; i--) begin
        cand = IW'((int'(ptr_q) + i) % NREQ);
        if (i_req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) begin
        gnt   = NREQ'(1) << win;
        ptr_d = win;
        if (i_lock[win]) begin
          state_d = OWN;
          owner_d = win;
          left_d  = BURST_RELOAD;
        end
      end
    end
  end

  // BRAM port mux; address and data hold their last values when idle
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        mem_we    = i_we[k];
        mem_addr  = i_addr[k*AW +: AW];
        mem_wdata = i_wdata[k*DW +: DW];
      end
    end
  end

  // Held BRAM address/data and one-cycle-delayed read-valid
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
      rvalid_q <= gnt & ~i_we;
    end
  end

  assign o_gnt       = gnt;
  assign o_mem_en    = |gnt;
  assign o_mem_we    = mem_we;
  assign o_mem_addr  = mem_addr;
  assign o_mem_wdata = mem_wdata;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = i_mem_rdata;
  assign o_busy      = (state_q == OWN);

endmodule
